// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end: owns the PC, keeps up to MAX_OUT reads in
// flight to instruction memory, and buffers returned words (with their PC+4)
// in a DEPTH-entry FIFO that feeds the IF/ID register one entry per cycle.
// A jump flushes the FIFO and marks every in-flight read as "to be discarded".
module fetch_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req,
    output logic [31:0]             imem_addr,
    input  logic                    imem_rvalid,
    input  logic [31:0]             imem_rdata,
    input  logic                    jump_flag,
    input  logic [31:0]             jump_address,
    input  logic                    stall,
    output logic                    inst_valid,
    output logic [31:0]             Instrucction,
    output logic [31:0]             PC_4,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Fetch state
    logic [31:0]   r_pc;
    logic [1:0]    r_out_cnt;
    logic [1:0]    r_discard_cnt;

    // PC+4 tags of in-flight reads, in request order (4 slots cover MAX_OUT <= 3)
    logic [31:0]   r_tag [4];
    logic [1:0]    r_tag_wr;
    logic [1:0]    r_tag_rd;

    // Instruction FIFO
    logic [31:0]   r_fifo_instr [DEPTH];
    logic [31:0]   r_fifo_pc4   [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Last presented head, shown while the FIFO is empty
    logic [31:0]   r_last_instr;
    logic [31:0]   r_last_pc4;

    logic          w_resp;
    logic          w_keep;
    logic          w_drop;
    logic          w_pop;
    logic [7:0]    w_occ;
    logic [31:0]   w_pc_plus4;
    logic          w_unused_jump_lsb;

    // Low address bits of the jump target are forced to zero.
    assign w_unused_jump_lsb = &{1'b0, jump_address[1:0]};

    // Request/response/consume qualifiers; a response with nothing outstanding is ignored.
    always_comb begin
        w_occ      = 8'(r_count) + 8'(r_out_cnt);
        w_pc_plus4 = r_pc + 32'd4;
        w_resp     = imem_rvalid && (r_out_cnt != 2'd0);
        w_keep     = w_resp && (r_discard_cnt == 2'd0) && !jump_flag;
        w_drop     = w_resp && (r_discard_cnt != 2'd0);
        w_pop      = (r_count != CW'(0)) && !stall && !jump_flag;
        imem_addr  = r_pc;
        if (rst_n && !jump_flag && (r_out_cnt < 2'(MAX_OUT)) && (w_occ < 8'(DEPTH))) begin
            imem_req = 1'b1;
        end else begin
            imem_req = 1'b0;
        end
    end

    // PC, outstanding-read and discard bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_out_cnt     <= 2'd0;
            r_discard_cnt <= 2'd0;
            r_tag_wr      <= 2'd0;
            r_tag_rd      <= 2'd0;
        end else begin
            if (jump_flag) begin
                r_pc <= {jump_address[31:2], 2'b00};
            end else if (imem_req) begin
                r_pc <= w_pc_plus4;
            end
            case ({imem_req, w_resp})
                2'b10:   r_out_cnt <= r_out_cnt + 2'd1;
                2'b01:   r_out_cnt <= r_out_cnt - 2'd1;
                default: r_out_cnt <= r_out_cnt;
            endcase
            // Every read still in flight after a jump is stale.
            if (jump_flag) begin
                r_discard_cnt <= r_out_cnt - (w_resp ? 2'd1 : 2'd0);
            end else if (w_drop) begin
                r_discard_cnt <= r_discard_cnt - 2'd1;
            end
            if (imem_req) begin
                r_tag_wr <= r_tag_wr + 2'd1;
            end
            if (w_resp) begin
                r_tag_rd <= r_tag_rd + 2'd1;
            end
        end
    end

    // Tag storage: PC+4 of each issued read.
    always_ff @(posedge clk) begin
        if (imem_req) begin
            r_tag[r_tag_wr] <= w_pc_plus4;
        end
    end

    // FIFO pointers and occupancy; a jump empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (jump_flag) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_keep) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_keep, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO data storage.
    always_ff @(posedge clk) begin
        if (w_keep) begin
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
            r_fifo_pc4[r_wr_ptr]   <= r_tag[r_tag_rd];
        end
    end

    // Remember the head so outputs hold their value once the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_instr <= 32'd0;
            r_last_pc4   <= 32'd0;
        end else if (r_count != CW'(0)) begin
            r_last_instr <= r_fifo_instr[r_rd_ptr];
            r_last_pc4   <= r_fifo_pc4[r_rd_ptr];
        end
    end

    // Head-of-FIFO presentation to IF/ID.
    always_comb begin
        fifo_count = r_count;
        if (r_count != CW'(0)) begin
            inst_valid   = 1'b1;
            Instrucction = r_fifo_instr[r_rd_ptr];
            PC_4         = r_fifo_pc4[r_rd_ptr];
        end else begin
            inst_valid   = 1'b0;
            Instrucction = r_last_instr;
            PC_4         = r_last_pc4;
        end
    end

endmodule
